// File: rtl/addertree9_sched.sv
// addertree9_sched
//   Schedules jobs of nine-operand fp16 windows onto an external 9-input adder
//   tree. The tree is a one-stage pipeline: its output is valid one edge after
//   tree_a changes. Sums are collected in a small output FIFO. Issue is
//   throttled so that the FIFO can absorb every window already in flight,
//   which means the FIFO can never overflow.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; len sampled with start
//   RUN   | accepting windows until issued == len
//   DRAIN | all windows issued; waiting for retired == len, then done
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start, len       job request and window count (sampled in IDLE only)
//   in_valid/in_data/in_ready   operand window handshake (9 x fp16)
//   tree_a           registered operands to the adder tree
//   tree_dout        adder tree sum
//   out_valid/out_data/out_ready  result handshake (FIFO head)
//   busy             job active (RUN or DRAIN)
//   done             one-cycle pulse when a job completes
module addertree9_sched #(
  parameter int OBUF_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [143:0]     in_data,
  output logic             in_ready,
  output logic [143:0]     tree_a,
  input  logic [15:0]      tree_dout,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_P   = (PTR_W+2)'(OBUF_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_OCC = (PTR_W+1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, issued_q, retired_q;
  logic             v1_q, v2_q;
  logic [15:0]      obuf_q [OBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic [PTR_W+1:0] pending;
  logic             done_q, done_d, job_load;
  logic             accept, push, pop, last_issue, last_retire;

  // Buffered results plus windows still inside the tree pipeline.
  assign pending     = {1'b0, occ_q} + (PTR_W+2)'(v1_q) + (PTR_W+2)'(v2_q);
  assign in_ready    = (state_q == S_RUN) && (issued_q < len_q) && (pending < DEPTH_P);
  assign accept      = in_valid && in_ready;
  assign push        = v2_q;
  assign out_valid   = (occ_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = obuf_q[rd_ptr_q];
  assign last_issue  = (issued_q + LEN_W'(1)) == len_q;
  assign last_retire = (retired_q + LEN_W'(1)) == len_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    job_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d  = S_RUN;
            job_load = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept && last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && last_retire) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else if (job_load) begin
      len_q     <= len;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      if (accept) issued_q  <= issued_q + LEN_W'(1);
      if (pop)    retired_q <= retired_q + LEN_W'(1);
    end
  end

  // v1/v2 tag the window in tree_a and the window whose sum is on tree_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tree_a <= '0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) tree_a <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) obuf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        obuf_q[wr_ptr_q] <= tree_dout;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // The issue throttle makes a push into a full buffer unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (occ_q == DEPTH_OCC)));

endmodule

// File: tb/tb_addertree9_sched.sv
module tb_addertree9_sched;
  localparam int OBUF_DEPTH = 4;
  localparam int LEN_W      = 16;

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [143:0]     in_data = '0;
  logic             in_ready, out_valid, busy, done;
  logic [143:0]     tree_a;
  logic [15:0]      tree_dout = '0;
  logic [15:0]      out_data;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [143:0] win [1024];
  int n_acc, pops, acc_before_pop, data_bad, done_cnt, done_edge, last_pop_edge;
  int first_acc_edge, last_acc_edge, first_ov_edge, max_out;
  logic [15:0] first_data, bad_act, bad_exp;
  bit timed_out;
  logic [15:0] exp_q [$];

  addertree9_sched #(.OBUF_DEPTH(OBUF_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tree_a(tree_a), .tree_dout(tree_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fp16 helpers for the reference tree (normal, finite values only)
  function automatic real h2r(input logic [15:0] h);
    real r;
    int e;
    e = int'(h[14:10]);
    r = real'(h[9:0]) / 1024.0;
    if (e != 0) r = r + 1.0;
    else e = 1;
    e = e - 15;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real a;
    int e, m;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    if (m == 1024) begin m = 0; e++; end
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] tree_ref(input logic [143:0] w);
    real s;
    s = 0.0;
    for (int i = 0; i < 9; i++) s = s + h2r(w[16*i +: 16]);
    return r2h(s);
  endfunction

  function automatic logic [143:0] rand_win();
    logic [143:0] w;
    for (int i = 0; i < 9; i++)
      w[16*i +: 16] = {1'b0, 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
    return w;
  endfunction

  // External adder tree: one register stage.
  always @(posedge clk) tree_dout <= tree_ref(tree_a);

  task automatic start_job(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives windows/consumer and records what happened; tests judge the records.
  task automatic run_traffic(input int n_win, input int p_valid, input int p_ready,
                             input int ready_hold, input int restart_at, input int max_cyc);
    int idx, k, quiet;
    bit seen_ov;
    logic [15:0] e;
    idx = 0; k = 0; quiet = 0; seen_ov = 1'b0;
    n_acc = 0; pops = 0; acc_before_pop = 0; data_bad = 0; done_cnt = 0;
    done_edge = -1; last_pop_edge = -2; first_acc_edge = -1; last_acc_edge = -1;
    first_ov_edge = -1; max_out = 0; first_data = '0; bad_act = '0; bad_exp = '0;
    exp_q.delete();
    while (k < max_cyc) begin
      start = (k == restart_at);
      if (k == restart_at) len = 16'd2;
      if (idx < n_win) in_valid = ($urandom_range(1, 100) <= p_valid);
      else in_valid = (p_valid == 100);
      in_data   = (in_valid && idx < n_win) ? win[idx] : rand_win();
      out_ready = (k >= ready_hold) && ($urandom_range(1, 100) <= p_ready);
      @(negedge clk);
      if (n_acc - pops > max_out) max_out = n_acc - pops;
      if (in_valid && in_ready) begin
        if (n_acc == 0) first_acc_edge = cyc + 1;
        last_acc_edge = cyc + 1;
        if (pops == 0) acc_before_pop++;
        if (idx < n_win) begin
          exp_q.push_back(tree_ref(win[idx]));
          idx++;
        end
        n_acc++;
      end
      if (out_valid && !seen_ov) begin
        seen_ov = 1'b1;
        first_ov_edge = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          if (data_bad == 0) begin bad_act = out_data; bad_exp = 16'hxxxx; end
          data_bad++;
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            if (data_bad == 0) begin bad_act = out_data; bad_exp = e; end
            data_bad++;
          end
        end
        if (pops == 0) first_data = out_data;
        pops++;
        last_pop_edge = cyc + 1;
      end
      if (done) begin done_cnt++; done_edge = cyc; end
      if (pops >= n_win) quiet++;
      @(posedge clk); #1;
      k++;
      if (quiet >= 4) break;
    end
    timed_out = (pops < n_win);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (tree_a !== 144'h0) begin n_bad++; $display("FAIL reset_tree_a: got %h want 0", tree_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) win[i] = {9{16'h3C00}};
    start_job(16'd3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    run_traffic(3, 100, 100, 0, -1, 200);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: got %0d pops want 3", pops); end
    n_cmp++; if (n_acc != 3) begin n_bad++; $display("FAIL basic_accepts: got %0d want 3", n_acc); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL basic_data: got %h want %h (%0d bad)", bad_act, bad_exp, data_bad); end
    n_cmp++; if (first_data !== 16'h4880) begin n_bad++; $display("FAIL basic_sum9: got %h want 4880", first_data); end
    n_cmp++; if (first_ov_edge - first_acc_edge != 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", first_ov_edge - first_acc_edge); end
    n_cmp++; if (last_acc_edge - first_acc_edge != 2) begin n_bad++; $display("FAIL basic_throughput: got %0d want 2", last_acc_edge - first_acc_edge); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_edge != last_pop_edge) begin n_bad++; $display("FAIL basic_done_timing: got %0d want %0d", done_edge, last_pop_edge); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) win[i] = rand_win();
    start_job(16'd8);
    run_traffic(8, 100, 100, 12, -1, 300);
    n_cmp++; if (acc_before_pop != 4) begin n_bad++; $display("FAIL bp_stall_point: got %0d want 4", acc_before_pop); end
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout: got %0d pops want 8", pops); end
    n_cmp++; if (n_acc != 8) begin n_bad++; $display("FAIL bp_accepts: got %0d want 8", n_acc); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL bp_data: got %h want %h (%0d bad)", bad_act, bad_exp, data_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (max_out > OBUF_DEPTH) begin n_bad++; $display("FAIL bp_outstanding: got %0d want <= %0d", max_out, OBUF_DEPTH); end
  endtask

  task automatic test_len_zero();
    start_job(16'd0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL len0_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL len0_done: got %b want 1", done); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL len0_done_drop: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 5; i++) win[i] = rand_win();
    start_job(16'd5);
    run_traffic(5, 100, 100, 0, 2, 200);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL restart_timeout: got %0d pops want 5", pops); end
    n_cmp++; if (n_acc != 5) begin n_bad++; $display("FAIL restart_accepts: got %0d want 5", n_acc); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL restart_data: got %h want %h (%0d bad)", bad_act, bad_exp, data_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_midjob();
    for (int i = 0; i < 8; i++) win[i] = rand_win();
    start_job(16'd8);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = win[i];
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pre_in_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL mid_out_data: got %h want 0000", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (tree_a !== 144'h0) begin n_bad++; $display("FAIL mid_tree_a: got %h want 0", tree_a); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) win[i] = rand_win();
    start_job(16'd2);
    run_traffic(2, 100, 100, 0, -1, 100);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL mid_new_timeout: got %0d pops want 2", pops); end
    n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL mid_new_accepts: got %0d want 2", n_acc); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL mid_new_data: got %h want %h (%0d bad)", bad_act, bad_exp, data_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL mid_new_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) win[i] = rand_win();
    start_job(16'd1000);
    run_traffic(1000, 70, 60, 0, -1, 20000);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL rand_timeout: got %0d pops want 1000", pops); end
    n_cmp++; if (n_acc != 1000) begin n_bad++; $display("FAIL rand_accepts: got %0d want 1000", n_acc); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL rand_data: got %h want %h (%0d bad)", bad_act, bad_exp, data_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL rand_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_edge != last_pop_edge) begin n_bad++; $display("FAIL rand_done_timing: got %0d want %0d", done_edge, last_pop_edge); end
    n_cmp++; if (max_out > OBUF_DEPTH) begin n_bad++; $display("FAIL rand_outstanding: got %0d want <= %0d", max_out, OBUF_DEPTH); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rand_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_restart_ignored();
    test_reset_midjob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
